// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - two-source turning actuator scheduler: pending slots, arbitration, turn and settle timing
// Optional: define TURN_SCHED_ROUND_ROBIN_EN for round-robin arbitration of simultaneous sources (default: A wins).
module turn_scheduler #(
  parameter int TURN_TICKS   = 90,
  parameter int SETTLE_TICKS = 50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [2:0] i_a_req,
  input  logic [2:0] i_b_req,
  output logic       o_a_grant,
  output logic       o_b_grant,
  output logic       o_turn_left,
  output logic       o_turn_right,
  output logic       o_exit_forward,
  output logic       o_is_turning,
  output logic       o_drop_flag
);

  localparam int TURN_CW   = $clog2(2 * TURN_TICKS);
  localparam int SETTLE_CW = $clog2(SETTLE_TICKS);
  localparam int CW_RAW    = (TURN_CW > SETTLE_CW) ? TURN_CW : SETTLE_CW;
  localparam int CW        = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0] TURN_LOAD   = CW'(TURN_TICKS - 1);
  localparam logic [CW-1:0] BACK_LOAD   = CW'(2 * TURN_TICKS - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_TURN, ST_SETTLE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_dir;
  logic [2:0]    r_pend_a;
  logic [2:0]    r_pend_b;
  logic          r_a_grant, r_b_grant, r_turn_left, r_turn_right;
  logic          r_exit_forward, r_is_turning, r_drop_flag;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_dir_nxt;
  logic [2:0]    w_a_new, w_b_new;
  logic          w_pick_b;
  logic          w_grant_a, w_grant_b, w_left, w_right, w_fwd, w_turning;

  // Multi-bit requests collapse to one direction: left > right > back.
  function automatic logic [2:0] f_pick(input logic [2:0] req);
    if (req[0])      return 3'b001;
    else if (req[1]) return 3'b010;
    else if (req[2]) return 3'b100;
    else             return 3'b000;
  endfunction

  assign w_a_new = f_pick(i_a_req);
  assign w_b_new = f_pick(i_b_req);

`ifdef TURN_SCHED_ROUND_ROBIN_EN
  logic r_favour_b;

  assign w_pick_b = (r_pend_b != 3'b000) && ((r_pend_a == 3'b000) || r_favour_b);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_favour_b <= 1'b0;
    end else if (w_grant_a || w_grant_b) begin
      r_favour_b <= w_grant_a;
    end
  end
`else
  assign w_pick_b = (r_pend_b != 3'b000) && (r_pend_a == 3'b000);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_left      = 1'b0;
    w_right     = 1'b0;
    w_fwd       = 1'b0;
    w_turning   = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((r_pend_a != 3'b000) || (r_pend_b != 3'b000)) begin
            w_dir_nxt   = w_pick_b ? r_pend_b : r_pend_a;
            w_grant_a   = !w_pick_b;
            w_grant_b   = w_pick_b;
            w_state_nxt = ST_TURN;
            w_cnt_nxt   = w_dir_nxt[2] ? BACK_LOAD : TURN_LOAD;
            w_left      = w_dir_nxt[0] | w_dir_nxt[2];
            w_right     = w_dir_nxt[1];
            w_turning   = 1'b1;
          end
        end
        ST_TURN: begin
          w_turning = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = SETTLE_LOAD;
            w_fwd       = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            w_left    = r_dir[0] | r_dir[2];
            w_right   = r_dir[1];
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            w_fwd     = 1'b1;
            w_turning = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // A new request on the grant edge wins over the slot clear and is not a drop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_a    <= 3'b000;
      r_pend_b    <= 3'b000;
      r_drop_flag <= 1'b0;
    end else if (!i_enable) begin
      r_pend_a <= 3'b000;
      r_pend_b <= 3'b000;
    end else begin
      if (w_a_new != 3'b000) begin
        if ((r_pend_a == 3'b000) || w_grant_a) r_pend_a <= w_a_new;
        else r_drop_flag <= 1'b1;
      end else if (w_grant_a) begin
        r_pend_a <= 3'b000;
      end
      if (w_b_new != 3'b000) begin
        if ((r_pend_b == 3'b000) || w_grant_b) r_pend_b <= w_b_new;
        else r_drop_flag <= 1'b1;
      end else if (w_grant_b) begin
        r_pend_b <= 3'b000;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_dir          <= 3'b000;
      r_a_grant      <= 1'b0;
      r_b_grant      <= 1'b0;
      r_turn_left    <= 1'b0;
      r_turn_right   <= 1'b0;
      r_exit_forward <= 1'b0;
      r_is_turning   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_dir          <= w_dir_nxt;
      r_a_grant      <= w_grant_a;
      r_b_grant      <= w_grant_b;
      r_turn_left    <= w_left;
      r_turn_right   <= w_right;
      r_exit_forward <= w_fwd;
      r_is_turning   <= w_turning;
    end
  end

  assign o_a_grant      = r_a_grant;
  assign o_b_grant      = r_b_grant;
  assign o_turn_left    = r_turn_left;
  assign o_turn_right   = r_turn_right;
  assign o_exit_forward = r_exit_forward;
  assign o_is_turning   = r_is_turning;
  assign o_drop_flag    = r_drop_flag;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - scoreboard bench for turn_scheduler (TURN_TICKS=4, SETTLE_TICKS=3)
module tb_turn_scheduler;

  logic       clk, rst, enable;
  logic [2:0] a_req, b_req;
  logic       a_grant, b_grant, turn_left, turn_right, exit_forward, is_turning, drop_flag;
  logic [6:0] outs;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    logic [47:0] sig;
    int          start;
  } exp_t;

  typedef struct {
    logic [47:0] sig;
    int          start;
    int          stop;
    logic [6:0]  end_outs;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  turn_scheduler #(.TURN_TICKS(4), .SETTLE_TICKS(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_a_req(a_req), .i_b_req(b_req),
    .o_a_grant(a_grant), .o_b_grant(b_grant), .o_turn_left(turn_left),
    .o_turn_right(turn_right), .o_exit_forward(exit_forward),
    .o_is_turning(is_turning), .o_drop_flag(drop_flag)
  );

  assign outs = {a_grant, b_grant, turn_left, turn_right, exit_forward, is_turning, drop_flag};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Shape of one turn: grant-a cycles, grant-b cycles, left, right, forward, is_turning cycles.
  function automatic logic [47:0] mk(input int ga, input int gb, input int l, input int r, input int f, input int t);
    return {ga[7:0], gb[7:0], l[7:0], r[7:0], f[7:0], t[7:0]};
  endfunction

  task automatic push_exp(input logic [47:0] sig, input int start);
    exp_t e;
    e.sig   = sig;
    e.start = start;
    exp_q.push_back(e);
  endtask

  task automatic observe_turns(input int n, input int bound);
    obs_t o;
    int t, na, nb, nl, nr, nf, nt;
    for (int k = 0; k < n; k++) begin
      o.sig = '0; o.start = -1; o.stop = -1; o.end_outs = '1;
      t = 0;
      @(negedge clk);
      while (!is_turning && t < bound) begin
        @(negedge clk);
        t++;
      end
      if (is_turning) begin
        o.start = cyc;
        na = 0; nb = 0; nl = 0; nr = 0; nf = 0; nt = 0;
        while (is_turning && t < bound + 400) begin
          na += int'(a_grant); nb += int'(b_grant); nl += int'(turn_left);
          nr += int'(turn_right); nf += int'(exit_forward); nt++;
          @(negedge clk);
          t++;
        end
        o.sig      = mk(na, nb, nl, nr, nf, nt);
        o.stop     = cyc;
        o.end_outs = outs;
      end
      obs_q.push_back(o);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; a_req = 3'b000; b_req = 3'b000;
    exp_q.delete();
    obs_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: actual %b required %b", outs, 7'b0); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL post_reset_idle: actual %b required %b", outs, 7'b0); end
  endtask

  task automatic test_single_left();
    exp_t e; obs_t o;
    do_reset();
    fork
      begin
        @(posedge clk); #1 a_req = 3'b001; push_exp(mk(1, 0, 4, 0, 3, 7), cyc + 2);
        @(posedge clk); #1 a_req = 3'b000;
      end
      observe_turns(1, 50);
    join
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_checks++;
    if (o.sig !== e.sig) begin n_fail++; $display("FAIL single_left_shape: actual %h required %h", o.sig, e.sig); end
    n_checks++;
    if (o.start !== e.start) begin n_fail++; $display("FAIL single_left_latency: actual %0d required %0d", o.start, e.start); end
    n_checks++;
    if (o.end_outs !== 7'b0) begin n_fail++; $display("FAIL single_left_end: actual %b required %b", o.end_outs, 7'b0); end
  endtask

  task automatic test_back_b();
    exp_t e; obs_t o;
    do_reset();
    fork
      begin
        @(posedge clk); #1 b_req = 3'b100; push_exp(mk(0, 1, 8, 0, 3, 11), cyc + 2);
        @(posedge clk); #1 b_req = 3'b000;
      end
      observe_turns(1, 50);
    join
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_checks++;
    if (o.sig !== e.sig) begin n_fail++; $display("FAIL back_b_shape: actual %h required %h", o.sig, e.sig); end
    n_checks++;
    if (o.start !== e.start) begin n_fail++; $display("FAIL back_b_latency: actual %0d required %0d", o.start, e.start); end
  endtask

  task automatic test_back_to_back_drop();
    exp_t e; obs_t o; int prev;
    do_reset();
    fork
      begin
        @(posedge clk); #1 a_req = 3'b001; push_exp(mk(1, 0, 4, 0, 3, 7), cyc + 2);
        @(posedge clk); #1 a_req = 3'b000;
        repeat (3) @(posedge clk);
        #1 a_req = 3'b010; push_exp(mk(1, 0, 0, 4, 3, 7), -1);
        @(posedge clk); #1 a_req = 3'b000;
        n_checks++;
        if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL buffer_no_drop: actual %b required 0", drop_flag); end
        repeat (2) @(posedge clk);
        #1 a_req = 3'b100;
        @(posedge clk); #1 a_req = 3'b000;
      end
      observe_turns(2, 50);
    join
    prev = 0;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.sig !== e.sig) begin n_fail++; $display("FAIL b2b_shape[%0d]: actual %h required %h", k, o.sig, e.sig); end
      n_checks++;
      if (o.start !== ((e.start >= 0) ? e.start : prev + 1))
        begin n_fail++; $display("FAIL b2b_start[%0d]: actual %0d required %0d", k, o.start, (e.start >= 0) ? e.start : prev + 1); end
      prev = o.stop;
    end
    observe_turns(1, 20);
    o = obs_q.pop_front();
    n_checks++;
    if (o.start !== -1) begin n_fail++; $display("FAIL dropped_not_run: actual start %0d required none", o.start); end
    n_checks++;
    if (drop_flag !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: actual %b required 1", drop_flag); end
    do_reset();
    n_checks++;
    if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL drop_cleared_by_rst: actual %b required 0", drop_flag); end
  endtask

  task automatic test_simultaneous();
    exp_t e; obs_t o; int prev;
    do_reset();
    fork
      begin
        @(posedge clk); #1 a_req = 3'b001; b_req = 3'b010;
        push_exp(mk(1, 0, 4, 0, 3, 7), cyc + 2);
`ifdef TURN_SCHED_ROUND_ROBIN_EN
        push_exp(mk(0, 1, 0, 4, 3, 7), -1);
        push_exp(mk(1, 0, 8, 0, 3, 11), -1);
`else
        push_exp(mk(1, 0, 8, 0, 3, 11), -1);
        push_exp(mk(0, 1, 0, 4, 3, 7), -1);
`endif
        @(posedge clk); #1 a_req = 3'b000; b_req = 3'b000;
        repeat (2) @(posedge clk);
        #1 a_req = 3'b100;
        @(posedge clk); #1 a_req = 3'b000;
      end
      observe_turns(3, 50);
    join
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.sig !== e.sig) begin n_fail++; $display("FAIL contest_shape[%0d]: actual %h required %h", k, o.sig, e.sig); end
      n_checks++;
      if (o.start !== ((e.start >= 0) ? e.start : prev + 1))
        begin n_fail++; $display("FAIL contest_start[%0d]: actual %0d required %0d", k, o.start, (e.start >= 0) ? e.start : prev + 1); end
      prev = o.stop;
    end
    n_checks++;
    if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL contest_no_drop: actual %b required 0", drop_flag); end
  endtask

  task automatic test_abort();
    int nt;
    do_reset();
    @(posedge clk); #1 a_req = 3'b001; b_req = 3'b010;
    @(posedge clk); #1 a_req = 3'b000; b_req = 3'b000;
    @(posedge clk); #1;
    n_checks++;
    if (turn_left !== 1'b1) begin n_fail++; $display("FAIL abort_turn_active: actual %b required 1", turn_left); end
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL enable_low_outputs: actual %b required %b", outs, 7'b0); end
    a_req = 3'b001;
    @(posedge clk); #1 a_req = 3'b000; enable = 1'b1;
    nt = 0;
    repeat (20) begin
      @(negedge clk);
      if (is_turning) nt++;
    end
    n_checks++;
    if (nt !== 0) begin n_fail++; $display("FAIL enable_low_slots_cleared: actual %0d turning cycles required 0", nt); end
    n_checks++;
    if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL enable_low_no_drop: actual %b required 0", drop_flag); end
    @(posedge clk); #1 a_req = 3'b001;
    @(posedge clk); #1 a_req = 3'b000;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (exit_forward !== 1'b1) begin n_fail++; $display("FAIL mid_settle_forward: actual %b required 1", exit_forward); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== 7'b0) begin n_fail++; $display("FAIL async_reset_outputs: actual %b required %b", outs, 7'b0); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_multibit();
    exp_t e; obs_t o; int prev;
    do_reset();
    fork
      begin
        @(posedge clk); #1 a_req = 3'b111;
        push_exp(mk(1, 0, 4, 0, 3, 7), cyc + 2);
        push_exp(mk(1, 0, 4, 0, 3, 7), -1);
        @(posedge clk); #1 a_req = 3'b001;
        @(posedge clk); #1 a_req = 3'b000;
      end
      observe_turns(2, 50);
    join
    prev = 0;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.sig !== e.sig) begin n_fail++; $display("FAIL multibit_shape[%0d]: actual %h required %h", k, o.sig, e.sig); end
      n_checks++;
      if (o.start !== ((e.start >= 0) ? e.start : prev + 1))
        begin n_fail++; $display("FAIL multibit_start[%0d]: actual %0d required %0d", k, o.start, (e.start >= 0) ? e.start : prev + 1); end
      prev = o.stop;
    end
    n_checks++;
    if (drop_flag !== 1'b0) begin n_fail++; $display("FAIL grant_edge_capture_no_drop: actual %b required 0", drop_flag); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; a_req = 3'b000; b_req = 3'b000;
    test_reset();
    test_single_left();
    test_back_b();
    test_back_to_back_drop();
    test_simultaneous();
    test_abort();
    test_multibit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Sequences the car's shared turning actuator between two requesters: the semi-auto navigator (source A) and the manual/remote command path (source B). Each source issues one-cycle left/right/back turn pulses. The block buffers one pending request per source, arbitrates between them, and drives the steering outputs for a fixed tick count. It then runs a forward settle phase and generates the `is_turning` status that both requesters consume.

## Interface
- `TURN_TICKS`, default 90: clock cycles for a 90° turn; must be ≥1.
- `SETTLE_TICKS`, default 50: forward-exit cycles after a turn; must be ≥1.
- `clk` in 1: drive clock, 500 Hz tick.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: block enable; low forces idle.
- `a_req` in 3: source A request pulses, bit order {back, right, left}.
- `b_req` in 3: source B request pulses, same bit order.
- `a_grant` out 1: one-cycle pulse when A's pending request starts.
- `b_grant` out 1: one-cycle pulse when B's pending request starts.
- `turn_left` out 1: steering drive, left.
- `turn_right` out 1: steering drive, right.
- `exit_forward` out 1: forward drive during settle.
- `is_turning` out 1: high during TURN and SETTLE.
- `drop_flag` out 1: sticky; a request was discarded because its slot was full.

## Operation
- **Pending slots:** 3-bit `pend_a` and `pend_b`.
  - A nonzero request is captured only when `enable` is high and the slot is empty.
  - If the slot is full, the request is discarded and `drop_flag` is set.
  - Multiple bits in one request: left > right > back; only the winning bit is stored.
- **FSM:** IDLE, TURN, SETTLE.
- **IDLE → TURN:** on any nonzero slot.
  - Latch the winning source and direction.
  - Clear that source's slot and pulse its grant.
  - Load the counter with TURN_TICKS-1, or 2·TURN_TICKS-1 for back.
- **TURN:** drive the steering output for the latched direction.
  - Left: `turn_left`=1.
  - Right: `turn_right`=1.
  - Back: `turn_left`=1, spin for a double-length turn.
  - Decrement each cycle; at 0, go to SETTLE with counter SETTLE_TICKS-1.
- **SETTLE:** `exit_forward`=1. Decrement; at 0, go to IDLE.
- **Same-source capture at grant edge:** a new request from the granted source on that edge is captured, because the new request takes precedence over the clear. It is not a drop.
- **Enable low:** on the next edge, the FSM goes to IDLE, both slots are cleared, and all drive outputs and grants are low. Incoming requests are ignored while low. `drop_flag` is held.
- **`drop_flag`:** cleared only by `rst`.
- **Counter width:** ceil(log2(2·TURN_TICKS)) or ceil(log2(SETTLE_TICKS)), whichever is larger, minimum 1. No wrap; the counter is reloaded at every state entry.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, slots empty, counter 0, round-robin pointer favours A.
- All outputs are registered. No combinational path from inputs to outputs.
- **Request latency:** a request sampled at edge N is in its slot after N. TURN is entered at edge N+1.
  - `turn_*`, `is_turning` and the grant go high in the cycle following N+1.
  - Request to actuator: 2 edges.
- **Durations:**
  - TURN lasts exactly TURN_TICKS cycles, or 2·TURN_TICKS for back.
  - SETTLE lasts exactly SETTLE_TICKS cycles.
  - `is_turning` is continuous across the TURN → SETTLE transition.
- **Back-to-back requests:** at least one IDLE cycle separates SETTLE from the next TURN. The grant pulse coincides with the first TURN cycle.
- **Reset mid-operation:** all outputs drop to 0 immediately, asynchronously.

## Configuration
- **`TURN_SCHED_ROUND_ROBIN_EN` defined:**
  - When both slots are pending in IDLE, the source not granted last wins.
  - The pointer updates on each grant.
- **Undefined:** source A always wins a simultaneous contest. There is no pointer register.

## Test plan
Parameters for all scenarios: TURN_TICKS=4, SETTLE_TICKS=3. Scenario 4 is run under both macro settings.

1. **Single left from A.** `a_req`=001 for 1 cycle → `a_grant` 1 cycle, `turn_left` 4 cycles, `exit_forward` 3 cycles, `is_turning` 7 continuous cycles, then all outputs 0.
2. **Back from B.** `b_req`=100 → `b_grant`, `turn_left` 8 cycles, settle 3 cycles. `a_grant` stays 0.
3. **Buffering and drops.** `a_req`=010 during an active turn → held, executed after one IDLE cycle. A second `a_req` while held → discarded, `drop_flag`=1 until `rst`.
4. **Simultaneous A and B pending.**
   - With macro: A, then B, then on the next contest B first.
   - Without macro: A always first.
5. **Enable and reset abort.**
   - `enable` low in TURN cycle 2 → next cycle all outputs 0, slots empty.
   - `rst` pulse mid-SETTLE → outputs 0 immediately.
6. **Multi-bit request.** `a_req`=111 → only left executed. A new `a_req`=001 on the grant edge → captured, `drop_flag` stays 0.
